fifo_burst_reader: RTL and testbench



---
 rtl/fifo_burst_reader.sv | 88 ++++++++
 tb/tb_fifo_burst_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains burst_len FIFO words into a valid/ready stream; FIFO_BURST_READER_TIMEOUT_EN adds a stall timeout
module fifo_burst_reader #(
  parameter int width = 16,
  parameter int LEN_W = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             fifo_read,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_data_out,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [LEN_W-1:0] rd_left, out_left;
  logic inflight, pop, stall_hit;
  logic [1:0] occ, wr_idx;
  logic [2:0] level;
  logic [width-1:0] b0, b1, b0_n, b1_n;
  always_comb begin
    pop = occ != 2'd0 && out_ready;
    level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    fifo_read = !rst && state == RUN && !fifo_empty && rd_left != '0 && level < 3'd2;
    wr_idx = occ - {1'b0, pop};
    b0_n = (inflight && wr_idx == 2'd0) ? fifo_data_out : pop ? b1 : b0;
    b1_n = (inflight && wr_idx == 2'd1) ? fifo_data_out : b1;
    state_n = state == IDLE ? (start ? (burst_len != '0 ? RUN : DONE) : IDLE)
            : state == RUN ? (((pop && out_left == LEN_W'(1)) || stall_hit) ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_left <= '0;
      out_left <= '0;
      inflight <= 1'b0;
      occ <= 2'd0;
      b0 <= '0;
      b1 <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        rd_left <= burst_len;
        out_left <= burst_len;
      end else begin
        if (fifo_read) rd_left <= rd_left - LEN_W'(1);
        if (pop) out_left <= out_left - LEN_W'(1);
      end
      inflight <= stall_hit ? 1'b0 : fifo_read;
      occ <= stall_hit ? 2'd0 : level[1:0];
      b0 <= b0_n;
      b1 <= b1_n;
    end
  end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] stall;
  logic tmo;
  assign stall_hit = state == RUN && stall == SW'(TIMEOUT_CYC);
  always_ff @(posedge clk) begin
    if (rst) begin
      stall <= '0;
      tmo <= 1'b0;
    end else begin
      stall <= (state != RUN || fifo_read || pop) ? '0 : stall + SW'(1);
      tmo <= stall_hit;
    end
  end
  assign timeout = tmo;
`else
  assign stall_hit = 1'b0;
  assign timeout = 1'b0;
`endif
  assign busy = state == RUN;
  assign done = state == DONE;
  assign out_valid = occ != 2'd0;
  assign out_data = b0;
  assign out_last = out_valid && out_left == LEN_W'(1);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: FIFO model, scoreboard and vector table driving fifo_burst_reader
module tb_fifo_burst_reader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [7:0] burst_len = 8'd0;
  logic [15:0] fifo_data_out = 16'd0;
  logic fifo_empty, fifo_read, busy, done, timeout, out_valid, out_last;
  logic [15:0] out_data;
  logic [15:0] mem [0:255];
  int wr_ptr = 0, rd_ptr = 0, reads = 0, xfers = 0, checks = 0, failures = 0;
  typedef struct packed {logic [15:0] d; logic l;} exp_t;
  exp_t exp_q[$];
  typedef struct {int len; logic [3:0] rdy; int exp_reads; int exp_xfers;} vec_t;
  vec_t tbl[6];
  logic hold_v = 1'b0, hold_l = 1'b0;
  logic [15:0] hold_d = 16'd0;
  always #5 clk = ~clk;
  assign fifo_empty = rd_ptr == wr_ptr;
  fifo_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .busy(busy), .done(done),
    .timeout(timeout), .fifo_read(fifo_read), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  always @(posedge clk) begin
    if (fifo_read) begin
      chk("read_on_empty", {31'd0, fifo_empty}, 32'd0);
      fifo_data_out <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
      reads++;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stable_valid", {31'd0, out_valid}, 32'd1);
        chk("stable_data", {16'd0, out_data}, {16'd0, hold_d});
        chk("stable_last", {31'd0, out_last}, {31'd0, hold_l});
      end
      if (out_valid && out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", {16'd0, out_data}, 32'hffffffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_data", {16'd0, out_data}, {16'd0, e.d});
          chk("sb_last", {31'd0, out_last}, {31'd0, e.l});
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic stage(input int n);
    for (int k = 0; k < n; k++) mem[wr_ptr + k] = 16'($urandom);
  endtask
  task automatic commit(input int n);
    wr_ptr = wr_ptr + n;
  endtask
  task automatic load(input int n);
    stage(n);
    commit(n);
  endtask
  task automatic start_burst(input int len);
    for (int k = 0; k < len; k++) begin
      exp_t e;
      e.d = mem[rd_ptr + k];
      e.l = k == len - 1;
      exp_q.push_back(e);
    end
    tick();
    start = 1'b1;
    burst_len = 8'(len);
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input string name, input logic [3:0] rdy, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) seen = 1;
      else begin
        out_ready = rdy[i % 4];
        tick();
      end
    end
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk({name, "_done_width"}, {31'd0, done}, 32'd0);
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    logic [7:0] e_rd, e_v, e_d, e_b;
    int rb, xb;
    bit reached;
    tbl[0] = '{1, 4'b1111, 1, 1};
    tbl[1] = '{2, 4'b0101, 2, 2};
    tbl[2] = '{6, 4'b1001, 6, 6};
    tbl[3] = '{5, 4'b0011, 5, 5};
    tbl[4] = '{8, 4'b1111, 8, 8};
    tbl[5] = '{3, 4'b0001, 3, 3};
    tick();
    tick();
    chk("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) mem[wr_ptr + k] = 16'(k + 1);
    commit(4);
    start_burst(4);
    e_rd = 8'b00001111;
    e_v = 8'b00111100;
    e_d = 8'b01000000;
    e_b = 8'b00111111;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t1_fifo_read_c%0d", c), {31'd0, fifo_read}, {31'd0, e_rd[c]});
      chk($sformatf("t1_out_valid_c%0d", c), {31'd0, out_valid}, {31'd0, e_v[c]});
      chk($sformatf("t1_done_c%0d", c), {31'd0, done}, {31'd0, e_d[c]});
      chk($sformatf("t1_busy_c%0d", c), {31'd0, busy}, {31'd0, e_b[c]});
      if (c >= 2 && c <= 5) begin
        chk($sformatf("t1_out_data_c%0d", c), {16'd0, out_data}, 32'(c - 1));
        chk($sformatf("t1_out_last_c%0d", c), {31'd0, out_last}, {31'd0, c == 5});
      end
      tick();
    end
    foreach (tbl[r]) begin
      load(tbl[r].len);
      rb = reads;
      xb = xfers;
      start_burst(tbl[r].len);
      wait_done($sformatf("row%0d", r), tbl[r].rdy, 200);
      chk($sformatf("row%0d_reads", r), 32'(reads - rb), 32'(tbl[r].exp_reads));
      chk($sformatf("row%0d_xfers", r), 32'(xfers - xb), 32'(tbl[r].exp_xfers));
      chk($sformatf("row%0d_sb_empty", r), 32'(exp_q.size()), 32'd0);
    end
    stage(3);
    commit(1);
    rb = reads;
    start_burst(3);
    tick();
    for (int i = 0; i < 9; i++) begin
      chk("t2_starved_read", {31'd0, fifo_read}, 32'd0);
      tick();
    end
    commit(2);
    wait_done("t2", 4'b1111, 50);
    chk("t2_reads", 32'(reads - rb), 32'd3);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    rb = reads;
    tick();
    start = 1'b1;
    burst_len = 8'd0;
    tick();
    start = 1'b0;
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("len0_done_once", {31'd0, done}, 32'd0);
    chk("len0_reads", 32'(reads - rb), 32'd0);
    load(8);
    rb = reads;
    start_burst(4);
    tick();
    start = 1'b1;
    burst_len = 8'd7;
    tick();
    start = 1'b0;
    wait_done("ign", 4'b1111, 50);
    repeat (3) tick();
    chk("ign_reads", 32'(reads - rb), 32'd4);
    chk("ign_busy", {31'd0, busy}, 32'd0);
    load(5);
    load(3);
    xb = xfers;
    start_burst(5);
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(negedge clk);
      #1;
      if (xfers - xb >= 2) reached = 1;
    end
    chk("rst_mid_reached", {31'd0, reached}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_xfers", 32'(xfers - xb), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_done", {31'd0, done}, 32'd0);
      tick();
    end
    rb = reads;
    start_burst(3);
    wait_done("post_rst", 4'b1111, 50);
    chk("post_rst_reads", 32'(reads - rb), 32'd3);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
